actuator_spi_passthrough: RTL and testbench
===========================================

Name: actuator_spi_passthrough

Overview:
- SPI slave front end of the actuator controller user project. It sits behind the mprj_io pads: enable_n, trigger_in_n, latch_data_n, miso, mosi, ss_n and sclk.
- Receives 32-bit MSB-first frames, mode 0 (CPOL=0, CPHA=0), and on the following frame shifts the previous frame's word back out on miso (loop-back/passthrough).
- Exposes the received word, a frame-valid strobe, a latched copy and a trigger pulse to downstream actuator logic.
- All external inputs are asynchronous to the system clock and are oversampled in that clock domain.

Parameters:
- DATA_WIDTH, 32, frame length and width of the data registers.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).

Ports:
- clock  input  1  system clock; must be at least 8x the sclk frequency (nominal 40 MHz vs 5 MHz).
- resetb  input  1  asynchronous active-low reset.
- enable_n  input  1  active-low block enable.
- ss_n  input  1  active-low SPI slave select.
- sclk  input  1  SPI clock; idles low.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out, MSB first.
- miso_oe  output  1  pad output enable for miso.
- latch_data_n  input  1  active-low request to latch rx_data.
- trigger_in_n  input  1  active-low external trigger.
- rx_data  output  DATA_WIDTH  last complete received frame.
- rx_valid  output  1  one-clock pulse when rx_data updates.
- latched_data  output  DATA_WIDTH  rx_data captured on a latch request.
- trigger  output  1  one-clock pulse on a trigger_in_n falling edge.

Behaviour:
- Reset (resetb low, asynchronous):
  - all synchroniser flops go to their idle value: ss_n, latch_data_n and trigger_in_n to 1; sclk and mosi to 0;
  - rx_data, latched_data, the tx shift register, the rx shift register and the bit counter are 0;
  - miso=0, miso_oe=0, rx_valid=0, trigger=0;
  - FSM goes to IDLE.
- Synchronisation:
  - sclk, ss_n, mosi, latch_data_n, trigger_in_n and enable_n each pass through SYNC_STAGES flops.
  - One further register per signal provides edge detection.
  - mosi is synchronised with the same depth as sclk, so mosi is sampled in the cycle the synchronised sclk rise is detected.
- FSM states:
  - IDLE: wait for ss_n fall with enable_n low, then go to SHIFT.
  - SHIFT: shift bits in and out as below.
  - DONE: one cycle; commit the frame, then return to IDLE.
- ss_n fall (synchronised) in IDLE:
  - tx_shift <= rx_data; miso = tx_shift[MSB] immediately;
  - miso_oe=1; bit counter=0.
- Synchronised sclk rise in SHIFT:
  - rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi}; counter+1.
  - When counter reaches DATA_WIDTH, go to DONE.
- Synchronised sclk fall in SHIFT:
  - tx_shift <= tx_shift<<1; miso follows tx_shift[MSB].
- DONE:
  - rx_data <= rx_shift; rx_valid=1 for exactly one cycle.
  - Further sclk edges before ss_n rises are ignored.
- ss_n rise:
  - miso_oe=0, miso=0; return to IDLE.
  - If fewer than DATA_WIDTH bits were received, the frame is discarded: rx_data unchanged, no rx_valid.
- enable_n high (synchronised):
  - forces IDLE at any point, aborting a frame in progress with no commit;
  - miso_oe=0; new frames are ignored.
  - rx_data and latched_data keep their values.
- latch_data_n falling edge with enable_n low: latched_data <= rx_data.
  - If this coincides with rx_valid, the newly committed value is latched.
- trigger_in_n falling edge with enable_n low: trigger=1 for one clock.
- Frames back to back: the next ss_n fall reloads tx_shift from the most recent rx_data.

Decomposition:
- Shared package actuator_pkg holds:
  - DATA_WIDTH default;
  - FSM state enum (IDLE, SHIFT, DONE);
  - idle-level constants for the synchronisers.
- One natural sub-module, sync_edge_detect, is instantiated once per input. It is parameterised by SYNC_STAGES and reset value, and outputs sync, rise and fall.

Test Plan:
- Reset, then enable_n=0, then frame 0xBEEFFACE -> rx_data=0xBEEFFACE, one rx_valid pulse; miso shifted during this frame = 0x00000000.
- Second frame 0x00000000 after frame 0xBEEFFACE -> bits captured on sclk rising edges from miso = 0xBEEFFACE; rx_data=0x00000000.
- ss_n raised after 16 bits of 0x12345678 -> rx_data unchanged, no rx_valid, miso_oe=0; next full frame 0xA5A5A5A5 is received correctly.
- enable_n=1 during a full frame 0xCAFEF00D -> rx_data unchanged, miso_oe stays 0.
- enable_n=1 mid-frame -> frame aborted with no commit.
- After frame 0x0F0F0F0F, pulse latch_data_n low -> latched_data=0x0F0F0F0F.
- Pulse trigger_in_n low for 3 clocks -> trigger pulses exactly once.
- resetb asserted mid-frame -> all outputs return to reset values asynchronously; the following frame starts clean and shifts out 0x00000000.

Source files
------------

// File: rtl/actuator_pkg.sv
// Shared definitions for the actuator SPI passthrough: default sizes,
// FSM state encoding and the idle levels the input synchronisers reset to.
package actuator_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    // Idle (inactive) levels of each pad input, used as synchroniser reset values.
    // enable_n resets to disabled so nothing happens until the pad is seen low.
    localparam logic IDLE_SS_N     = 1'b1;
    localparam logic IDLE_SCLK     = 1'b0;
    localparam logic IDLE_MOSI     = 1'b0;
    localparam logic IDLE_LATCH_N  = 1'b1;
    localparam logic IDLE_TRIG_N   = 1'b1;
    localparam logic IDLE_ENABLE_N = 1'b1;

endpackage

// File: rtl/actuator_spi_passthrough_if.sv
// Pad-side and downstream-side signals of the actuator SPI passthrough.
// master = SPI host / pad driver side, slave = the passthrough block.
interface actuator_spi_passthrough_if
    import actuator_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  enable_n;
    logic                  ss_n;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic                  latch_data_n;
    logic                  trigger_in_n;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] latched_data;
    logic                  trigger;

    modport master (
        output enable_n, ss_n, sclk, mosi, latch_data_n, trigger_in_n,
        input  miso, miso_oe, rx_data, rx_valid, latched_data, trigger
    );

    modport slave (
        input  enable_n, ss_n, sclk, mosi, latch_data_n, trigger_in_n,
        output miso, miso_oe, rx_data, rx_valid, latched_data, trigger
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input, followed by one extra
// register so rising and falling edges of the synchronised level can be seen.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clock,
    input  logic resetb,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the raw input through the synchroniser chain and keep the last level.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/actuator_spi_passthrough.sv
// SPI mode-0 slave front end: receives MSB-first frames, echoes the previous
// frame's word on miso during the next frame, and offers the received word,
// a latched copy and a trigger pulse to the actuator logic.
module actuator_spi_passthrough
    import actuator_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic                       clock,
    input logic                       resetb,
    actuator_spi_passthrough_if.slave spi
);
    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic latch_s, latch_rise, latch_fall;
    logic trig_s, trig_rise, trig_fall;
    logic en_n_s, en_rise, en_fall;

    spi_state_t            state, state_nxt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic [DATA_WIDTH-1:0] latched_q;
    logic                  rx_valid_q;
    logic                  trigger_q;
    logic                  miso_oe_q;

    logic load, shift_in, shift_out, commit;

    // Edge/level outputs of the synchronisers that this block has no use for.
    logic unused_edges;
    assign unused_edges = ^{sclk_s, ss_s, mosi_rise, mosi_fall, latch_s,
                            latch_rise, trig_s, trig_rise, en_rise, en_fall};

    // mosi uses the same depth as sclk so its synchronised value lines up
    // with the detected sclk rise.
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_SCLK)) u_sync_sclk (
        .clock(clock), .resetb(resetb), .d(spi.sclk),
        .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_SS_N)) u_sync_ss (
        .clock(clock), .resetb(resetb), .d(spi.ss_n),
        .sync(ss_s), .rise(ss_rise), .fall(ss_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_MOSI)) u_sync_mosi (
        .clock(clock), .resetb(resetb), .d(spi.mosi),
        .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_LATCH_N)) u_sync_latch (
        .clock(clock), .resetb(resetb), .d(spi.latch_data_n),
        .sync(latch_s), .rise(latch_rise), .fall(latch_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_TRIG_N)) u_sync_trig (
        .clock(clock), .resetb(resetb), .d(spi.trigger_in_n),
        .sync(trig_s), .rise(trig_rise), .fall(trig_fall));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_ENABLE_N)) u_sync_en (
        .clock(clock), .resetb(resetb), .d(spi.enable_n),
        .sync(en_n_s), .rise(en_rise), .fall(en_fall));

    // FSM state register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next state; a disabled block is held in IDLE, aborting any frame.
    always_comb begin
        state_nxt = state;
        if (en_n_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall) state_nxt = SHIFT;
                SHIFT: begin
                    if (ss_rise)
                        state_nxt = IDLE;
                    else if (sclk_rise && bit_cnt == LAST_BIT)
                        state_nxt = DONE;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: datapath strobes decoded from state and synchronised edges.
    always_comb begin
        load      = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        commit    = 1'b0;
        if (!en_n_s) begin
            load      = (state == IDLE) && ss_fall;
            shift_in  = (state == SHIFT) && !ss_rise && sclk_rise;
            shift_out = (state == SHIFT) && !ss_rise && sclk_fall;
            commit    = (state == DONE);
        end
    end

    // Shift registers and bit counter; tx reloads from the last committed word.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            tx_shift <= rx_data_q;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            if (shift_in) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            if (shift_out)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // miso drive enable: on from frame start until ss_n rises or the block is disabled.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb)                miso_oe_q <= 1'b0;
        else if (en_n_s || ss_rise) miso_oe_q <= 1'b0;
        else if (load)              miso_oe_q <= 1'b1;
    end

    // Frame commit; rx_valid is registered so it coincides with the new rx_data.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= commit;
            if (commit) rx_data_q <= rx_shift;
        end
    end

    // Latch request and trigger pulse; a latch during commit takes the new word.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            latched_q <= '0;
            trigger_q <= 1'b0;
        end else begin
            trigger_q <= !en_n_s && trig_fall;
            if (!en_n_s && latch_fall)
                latched_q <= commit ? rx_shift : rx_data_q;
        end
    end

    assign spi.miso         = miso_oe_q & tx_shift[DATA_WIDTH-1];
    assign spi.miso_oe      = miso_oe_q;
    assign spi.rx_data      = rx_data_q;
    assign spi.rx_valid     = rx_valid_q;
    assign spi.latched_data = latched_q;
    assign spi.trigger      = trigger_q;

endmodule

// File: tb/tb_actuator_spi_passthrough.sv
// Directed bench for actuator_spi_passthrough: a bench-side SPI host drives
// frames, a word-level model tracks what rx_data/latched_data must hold, and
// a per-cycle compare process checks the DUT against it.
module tb_actuator_spi_passthrough;
    localparam int DW = 32;
    localparam int H  = 6;    // sclk half period in system clocks (ratio 12x)

    logic clock  = 1'b0;
    logic resetb = 1'b1;
    always #5 clock = ~clock;

    actuator_spi_passthrough_if #(.DATA_WIDTH(DW)) bus ();

    actuator_spi_passthrough #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clock  (clock),
        .resetb (resetb),
        .spi    (bus)
    );

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            valid_cnt = 0;
    int            trig_cnt  = 0;
    logic          check_en  = 1'b0;
    logic [DW-1:0] exp_rx      = '0;
    logic [DW-1:0] exp_latched = '0;
    logic [DW-1:0] commit_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Per-cycle compare against the word-level model.
    always @(negedge clock) begin
        if (resetb) begin
            if (bus.rx_valid === 1'b1) begin
                valid_cnt++;
                if (commit_q.size() == 0)
                    chk("spurious_rx_valid", 32'(commit_q.size()), 32'd1);
                else
                    chk("rx_valid_data", bus.rx_data, commit_q.pop_front());
            end
            if (bus.trigger === 1'b1) trig_cnt++;
            if (check_en) begin
                chk("idle_rx_data", bus.rx_data, exp_rx);
                chk("idle_latched", bus.latched_data, exp_latched);
                chk("idle_miso_oe", 32'(bus.miso_oe), 32'd0);
                chk("idle_miso", 32'(bus.miso), 32'd0);
            end
        end
    end

    // One SPI mode-0 frame from the host side; miso sampled at each sclk rise.
    task automatic frame(input logic [DW-1:0] word, input int nbits, input int abort_at,
                         input int reset_at, output logic [DW-1:0] got, output logic oe_seen);
        got     = '0;
        oe_seen = 1'b0;
        bus.ss_n = 1'b0;
        bus.mosi = word[DW-1];
        cyc(2 * H);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) bus.enable_n = 1'b1;
            if (i == reset_at) begin
                #2 resetb = 1'b0;
                #1;
                chk("rst_async_rx_data", bus.rx_data, '0);
                chk("rst_async_latched", bus.latched_data, '0);
                chk("rst_async_rx_valid", 32'(bus.rx_valid), 32'd0);
                chk("rst_async_miso", 32'(bus.miso), 32'd0);
                chk("rst_async_miso_oe", 32'(bus.miso_oe), 32'd0);
                chk("rst_async_trigger", 32'(bus.trigger), 32'd0);
                bus.ss_n = 1'b1;
                bus.sclk = 1'b0;
                bus.mosi = 1'b0;
                cyc(3);
                resetb = 1'b1;
                return;
            end
            bus.mosi = word[DW-1-i];
            cyc(H);
            bus.sclk = 1'b1;
            got      = {got[DW-2:0], bus.miso};
            oe_seen  = oe_seen | bus.miso_oe;
            cyc(H);
            bus.sclk = 1'b0;
        end
        cyc(H);
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        cyc(H);
    endtask

    // Full frame with the model deciding whether it commits and what miso carries.
    task automatic full_frame(input logic [DW-1:0] word, output logic [DW-1:0] got);
        int   v0;
        logic enabled;
        logic oe;
        enabled  = (bus.enable_n == 1'b0);
        check_en = 1'b0;
        v0       = valid_cnt;
        if (enabled) commit_q.push_back(word);
        frame(word, DW, -1, -1, got, oe);
        cyc(8);
        chk("frame_miso_word", got, enabled ? exp_rx : '0);
        chk("frame_miso_oe", 32'(oe), 32'(enabled));
        chk("frame_valid_pulses", 32'(valid_cnt - v0), 32'(enabled));
        if (enabled) exp_rx = word;
        check_en = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got;
        logic          oe;
        int            v0, t0;

        bus.enable_n     = 1'b1;
        bus.ss_n         = 1'b1;
        bus.sclk         = 1'b0;
        bus.mosi         = 1'b0;
        bus.latch_data_n = 1'b1;
        bus.trigger_in_n = 1'b1;
        #2 resetb = 1'b0;
        cyc(4);
        chk("reset_rx_data", bus.rx_data, '0);
        chk("reset_latched", bus.latched_data, '0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("reset_miso", 32'(bus.miso), 32'd0);
        chk("reset_miso_oe", 32'(bus.miso_oe), 32'd0);
        chk("reset_trigger", 32'(bus.trigger), 32'd0);
        resetb = 1'b1;
        cyc(2);
        bus.enable_n = 1'b0;
        cyc(8);
        check_en = 1'b1;
        cyc(4);

        // First frame: nothing committed yet, so miso carries zeros.
        full_frame(32'hBEEFFACE, got);
        chk("first_miso_literal", got, 32'h0000_0000);
        chk("first_rx_literal", bus.rx_data, 32'hBEEFFACE);

        // Second frame echoes the first.
        full_frame(32'h0000_0000, got);
        chk("echo_miso_literal", got, 32'hBEEFFACE);
        chk("echo_rx_literal", bus.rx_data, 32'h0000_0000);

        // Short frame: 16 bits then ss_n rises; discarded.
        check_en = 1'b0;
        v0 = valid_cnt;
        frame(32'h12345678, 16, -1, -1, got, oe);
        cyc(8);
        chk("short_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        chk("short_rx_unchanged", bus.rx_data, 32'h0000_0000);
        chk("short_miso_oe_off", 32'(bus.miso_oe), 32'd0);
        check_en = 1'b1;
        full_frame(32'hA5A5A5A5, got);
        chk("after_short_miso", got, 32'h0000_0000);
        chk("after_short_rx", bus.rx_data, 32'hA5A5A5A5);

        // Disabled for the whole frame.
        bus.enable_n = 1'b1;
        cyc(6);
        full_frame(32'hCAFEF00D, got);
        chk("disabled_rx_literal", bus.rx_data, 32'hA5A5A5A5);
        bus.enable_n = 1'b0;
        cyc(6);

        // Disabled mid-frame at bit 10: aborted, no commit.
        check_en = 1'b0;
        v0 = valid_cnt;
        frame(32'h11223344, DW, 10, -1, got, oe);
        cyc(8);
        chk("abort_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        chk("abort_miso_oe_off", 32'(bus.miso_oe), 32'd0);
        bus.enable_n = 1'b0;
        cyc(6);
        chk("abort_rx_literal", bus.rx_data, 32'hA5A5A5A5);
        check_en = 1'b1;

        // Latch request after a committed frame.
        full_frame(32'h0F0F0F0F, got);
        chk("latch_frame_miso", got, 32'hA5A5A5A5);
        check_en = 1'b0;
        bus.latch_data_n = 1'b0;
        cyc(3);
        bus.latch_data_n = 1'b1;
        cyc(6);
        exp_latched = exp_rx;
        chk("latched_literal", bus.latched_data, 32'h0F0F0F0F);
        check_en = 1'b1;

        // Trigger held low for 3 clocks gives exactly one pulse.
        t0 = trig_cnt;
        bus.trigger_in_n = 1'b0;
        cyc(3);
        bus.trigger_in_n = 1'b1;
        cyc(8);
        chk("trigger_pulses", 32'(trig_cnt - t0), 32'd1);

        // No trigger while disabled.
        bus.enable_n = 1'b1;
        cyc(6);
        t0 = trig_cnt;
        bus.trigger_in_n = 1'b0;
        cyc(3);
        bus.trigger_in_n = 1'b1;
        cyc(8);
        chk("disabled_trigger_pulses", 32'(trig_cnt - t0), 32'd0);
        bus.enable_n = 1'b0;
        cyc(6);

        // Asynchronous reset in the middle of a frame.
        check_en = 1'b0;
        frame(32'h13572468, DW, -1, 10, got, oe);
        exp_rx      = '0;
        exp_latched = '0;
        commit_q.delete();
        cyc(8);
        check_en = 1'b1;
        cyc(2);
        full_frame(32'h600DF00D, got);
        chk("post_reset_miso", got, 32'h0000_0000);
        chk("post_reset_rx", bus.rx_data, 32'h600DF00D);

        cyc(4);
        chk("commit_queue_drained", 32'(commit_q.size()), 32'd0);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
